// File: rtl/mxint_bias_accumulator.sv
// Accumulates a configurable number of MXInt blocks into one block, aligning each beat to the
// running shared exponent, with an optional bias block folded in after the last data beat.
module mxint_bias_accumulator #(
    parameter  int IN_MAN_WIDTH   = 8,
    parameter  int IN_EXP_WIDTH   = 4,
    parameter  int BIAS_MAN_WIDTH = 8,
    parameter  int BLOCK_SIZE     = 4,
    parameter  int MAX_DEPTH      = 16,
    parameter  int HAS_BIAS       = 1,
    localparam int ACC_WIDTH      = IN_MAN_WIDTH + $clog2(MAX_DEPTH) + HAS_BIAS,
    localparam int CNT_WIDTH      = $clog2(MAX_DEPTH) + 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic        [CNT_WIDTH-1:0]      cfg_depth,
    input  logic signed [IN_MAN_WIDTH-1:0]   mdata_in [BLOCK_SIZE],
    input  logic        [IN_EXP_WIDTH-1:0]   edata_in,
    input  logic                             data_in_valid,
    output logic                             data_in_ready,
    input  logic signed [BIAS_MAN_WIDTH-1:0] mbias [BLOCK_SIZE],
    input  logic        [IN_EXP_WIDTH-1:0]   ebias,
    input  logic                             bias_valid,
    output logic                             bias_ready,
    output logic signed [ACC_WIDTH-1:0]      mdata_out [BLOCK_SIZE],
    output logic        [IN_EXP_WIDTH-1:0]   edata_out,
    output logic                             data_out_valid,
    input  logic                             data_out_ready,
    output logic        [CNT_WIDTH-1:0]      beat_count
);

    typedef enum logic [1:0] {
        S_ACC,
        S_BIAS,
        S_OUT
    } state_t;

    state_t                       state_q, state_d;
    logic        [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic        [CNT_WIDTH-1:0]  depth_q, depth_d, depth_eff;
    logic signed [ACC_WIDTH-1:0]  acc_q [BLOCK_SIZE];
    logic signed [ACC_WIDTH-1:0]  acc_d [BLOCK_SIZE];
    logic        [IN_EXP_WIDTH-1:0] exp_q, exp_d;

    logic                         load, first;
    logic signed [ACC_WIDTH-1:0]  op_m [BLOCK_SIZE];
    logic        [IN_EXP_WIDTH-1:0] op_e;
    int                           sh_up, sh_dn;

    function automatic logic [CNT_WIDTH-1:0] clamp_depth(input logic [CNT_WIDTH-1:0] d);
        if (d == '0)
            return CNT_WIDTH'(1);
        else if (d > CNT_WIDTH'(MAX_DEPTH))
            return CNT_WIDTH'(MAX_DEPTH);
        else
            return d;
    endfunction

    // Shifting by ACC_WIDTH-1 already yields 0 or -1, so larger distances collapse onto it.
    function automatic int sat_shift(input logic [IN_EXP_WIDTH-1:0] diff);
        return (int'(diff) >= ACC_WIDTH) ? ACC_WIDTH - 1 : int'(diff);
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        depth_d   = depth_q;
        depth_eff = depth_q;
        exp_d     = exp_q;
        acc_d     = acc_q;
        load      = 1'b0;
        first     = 1'b0;
        op_e      = edata_in;
        for (int unsigned i = 0; i < BLOCK_SIZE; i++) begin
            op_m[i] = ACC_WIDTH'(mdata_in[i]);
        end

        unique case (state_q)
            S_ACC: begin
                if (data_in_valid) begin
                    load  = 1'b1;
                    first = (cnt_q == '0);
                    cnt_d = cnt_q + 1'b1;
                    if (first) begin
                        depth_eff = clamp_depth(cfg_depth);
                        depth_d   = depth_eff;
                    end
                    if (cnt_d == depth_eff)
                        state_d = (HAS_BIAS != 0) ? S_BIAS : S_OUT;
                end
            end
            S_BIAS: begin
                if (bias_valid) begin
                    load = 1'b1;
                    op_e = ebias;
                    for (int unsigned i = 0; i < BLOCK_SIZE; i++) begin
                        op_m[i] = ACC_WIDTH'(IN_MAN_WIDTH'(mbias[i]));
                    end
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (data_out_ready) begin
                    state_d = S_ACC;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_ACC;
        endcase

        sh_up = sat_shift(op_e - exp_q);
        sh_dn = sat_shift(exp_q - op_e);
        if (load) begin
            if (first || (op_e >= exp_q))
                exp_d = op_e;
            for (int unsigned i = 0; i < BLOCK_SIZE; i++) begin
                if (first)
                    acc_d[i] = op_m[i];
                else if (op_e >= exp_q)
                    acc_d[i] = (acc_q[i] >>> sh_up) + op_m[i];
                else
                    acc_d[i] = acc_q[i] + (op_m[i] >>> sh_dn);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_ACC;
            cnt_q   <= '0;
            depth_q <= '0;
            exp_q   <= '0;
            for (int unsigned i = 0; i < BLOCK_SIZE; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            depth_q <= depth_d;
            exp_q   <= exp_d;
            acc_q   <= acc_d;
        end
    end

    assign data_in_ready  = (state_q == S_ACC) && !rst;
    assign bias_ready     = (HAS_BIAS != 0) && (state_q == S_BIAS);
    assign data_out_valid = (state_q == S_OUT);
    assign mdata_out      = acc_q;
    assign edata_out      = exp_q;
    assign beat_count     = cnt_q;

endmodule

// File: tb/tb_mxint_bias_accumulator.sv
// Drives a no-bias and a bias accumulator with directed and random blocks and checks every
// presented result against an integer model of the exponent-alignment rules.
module tb_mxint_bias_accumulator;

    localparam int BS  = 4;
    localparam int MW  = 8;
    localparam int EW  = 4;
    localparam int MD  = 16;
    localparam int CW  = $clog2(MD) + 1;
    localparam int AWA = MW + $clog2(MD);
    localparam int AWB = MW + $clog2(MD) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        [CW-1:0] cfg = '0;
    logic signed [MW-1:0] mdi [BS];
    logic signed [MW-1:0] mbi [BS];
    logic        [EW-1:0] edi = '0;
    logic        [EW-1:0] ebi = '0;
    logic dv_a = 1'b0, dv_b = 1'b0, bv_a = 1'b1, bv_b = 1'b0, rdy = 1'b0;

    logic                  dir_a, br_a, vo_a, dir_b, br_b, vo_b;
    logic signed [AWA-1:0] mo_a [BS];
    logic signed [AWB-1:0] mo_b [BS];
    logic        [EW-1:0]  eo_a, eo_b;
    logic        [CW-1:0]  bc_a, bc_b;

    mxint_bias_accumulator #(
        .IN_MAN_WIDTH(MW), .IN_EXP_WIDTH(EW), .BIAS_MAN_WIDTH(MW),
        .BLOCK_SIZE(BS), .MAX_DEPTH(MD), .HAS_BIAS(0)
    ) u_nb (
        .clk(clk), .rst(rst), .cfg_depth(cfg),
        .mdata_in(mdi), .edata_in(edi), .data_in_valid(dv_a), .data_in_ready(dir_a),
        .mbias(mbi), .ebias(ebi), .bias_valid(bv_a), .bias_ready(br_a),
        .mdata_out(mo_a), .edata_out(eo_a), .data_out_valid(vo_a), .data_out_ready(rdy),
        .beat_count(bc_a)
    );

    mxint_bias_accumulator #(
        .IN_MAN_WIDTH(MW), .IN_EXP_WIDTH(EW), .BIAS_MAN_WIDTH(MW),
        .BLOCK_SIZE(BS), .MAX_DEPTH(MD), .HAS_BIAS(1)
    ) u_b (
        .clk(clk), .rst(rst), .cfg_depth(cfg),
        .mdata_in(mdi), .edata_in(edi), .data_in_valid(dv_b), .data_in_ready(dir_b),
        .mbias(mbi), .ebias(ebi), .bias_valid(bv_b), .bias_ready(br_b),
        .mdata_out(mo_b), .edata_out(eo_b), .data_out_valid(vo_b), .data_out_ready(rdy),
        .beat_count(bc_b)
    );

    int n_vec = 0;
    int n_err = 0;
    int hs_a = 0, hs_b = 0;
    int rdy_mode = 0;
    int qm_a[$], qe_a[$], qm_b[$], qe_b[$];
    int m_acc[BS];
    int m_e;
    bit m_first;
    int ma[BS], mb[BS];

    task automatic chk(input string nm, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    // Arithmetic right shift as floor division by a power of two.
    function automatic int fshift(input int x, input int s);
        int d = 1 << s;
        int q = x / d;
        if ((x % d) != 0 && x < 0) q = q - 1;
        return q;
    endfunction

    function automatic void model_start();
        m_first = 1'b1;
    endfunction

    function automatic void model_add(input int m[BS], input int e);
        if (m_first) begin
            for (int i = 0; i < BS; i++) m_acc[i] = m[i];
            m_e = e;
            m_first = 1'b0;
        end else if (e >= m_e) begin
            for (int i = 0; i < BS; i++) m_acc[i] = fshift(m_acc[i], e - m_e) + m[i];
            m_e = e;
        end else begin
            for (int i = 0; i < BS; i++) m_acc[i] = m_acc[i] + fshift(m[i], m_e - e);
        end
    endfunction

    function automatic void push_expect(input int sel);
        for (int i = 0; i < BS; i++) begin
            if (sel == 0) qm_a.push_back(m_acc[i]); else qm_b.push_back(m_acc[i]);
        end
        if (sel == 0) qe_a.push_back(m_e); else qe_b.push_back(m_e);
    endfunction

    task automatic chk_port(input int sel, input logic v, input logic dr, input int m[BS], input int e);
        int qs;
        if (v) begin
            qs = (sel == 0) ? qe_a.size() : qe_b.size();
            if (qs == 0) begin
                chk($sformatf("unexpected_out%0d", sel), 1, 0);
            end else begin
                for (int i = 0; i < BS; i++)
                    chk($sformatf("out%0d_mant%0d", sel, i), m[i], (sel == 0) ? qm_a[i] : qm_b[i]);
                chk($sformatf("out%0d_exp", sel), e, (sel == 0) ? qe_a[0] : qe_b[0]);
                chk($sformatf("din_rdy_in_out%0d", sel), int'(dr), 0);
                if (rdy) begin
                    if (sel == 0) begin
                        repeat (BS) void'(qm_a.pop_front());
                        void'(qe_a.pop_front());
                        hs_a++;
                    end else begin
                        repeat (BS) void'(qm_b.pop_front());
                        void'(qe_b.pop_front());
                        hs_b++;
                    end
                end
            end
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < BS; i++) begin
            ma[i] = int'(mo_a[i]);
            mb[i] = int'(mo_b[i]);
        end
        if (rst) begin
            chk("rst_valid", int'(vo_a | vo_b), 0);
            chk("rst_din_rdy", int'(dir_a | dir_b), 0);
            chk("rst_bias_rdy", int'(br_a | br_b), 0);
            chk("rst_beat_count", int'(bc_a | bc_b), 0);
            chk("rst_exp", int'(eo_a | eo_b), 0);
            for (int i = 0; i < BS; i++) chk("rst_mant", ma[i] | mb[i], 0);
        end else begin
            chk_port(0, vo_a, dir_a, ma, int'(eo_a));
            chk_port(1, vo_b, dir_b, mb, int'(eo_b));
            chk("nobias_bias_rdy", int'(br_a), 0);
            if (br_b) chk("din_rdy_in_bias", int'(dir_b), 0);
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rdy_mode == 0) rdy = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void rand_lanes(output int m[BS]);
        for (int i = 0; i < BS; i++) m[i] = $urandom_range(0, 255) - 128;
    endfunction

    task automatic data_beat(input int sel, input int m[BS], input int e, input int k);
        logic r = 1'b0;
        int n = 0;
        for (int i = 0; i < BS; i++) mdi[i] = MW'(m[i]);
        edi = EW'(e);
        if (sel == 0) dv_a = 1'b1; else dv_b = 1'b1;
        while (!r && n < 100) begin
            @(negedge clk);
            r = (sel == 0) ? dir_a : dir_b;
            n++;
            @(posedge clk); #1;
        end
        dv_a = 1'b0;
        dv_b = 1'b0;
        if (!r) begin
            chk("data_accept_timeout", 0, 1);
        end else begin
            model_add(m, e);
            chk("beat_count", (sel == 0) ? int'(bc_a) : int'(bc_b), k);
        end
    endtask

    task automatic bias_beat(input int m[BS], input int e);
        logic r = 1'b0;
        int n = 0;
        for (int i = 0; i < BS; i++) mbi[i] = MW'(m[i]);
        ebi = EW'(e);
        bv_b = 1'b1;
        while (!r && n < 100) begin
            @(negedge clk);
            r = br_b;
            n++;
            @(posedge clk); #1;
        end
        bv_b = 1'b0;
        if (!r) chk("bias_accept_timeout", 0, 1);
        else model_add(m, e);
    endtask

    task automatic run_txn(input int sel, input int cfg_v, input bit chg);
        int d = (cfg_v == 0) ? 1 : ((cfg_v > MD) ? MD : cfg_v);
        int m[BS];
        cfg = CW'(cfg_v);
        model_start();
        for (int k = 1; k <= d; k++) begin
            rand_lanes(m);
            data_beat(sel, m, $urandom_range(0, 15), k);
            if (k == 1 && chg) cfg = CW'($urandom_range(0, 31));
        end
        if (sel == 1) begin
            rand_lanes(m);
            bias_beat(m, $urandom_range(0, 15));
        end
        push_expect(sel);
    endtask

    task automatic expect_lit(input int sel, input int m0, input int e);
        int n = 0;
        logic v = 1'b0;
        while (!v && n < 50) begin
            @(negedge clk);
            v = (sel == 0) ? vo_a : vo_b;
            n++;
        end
        if (!v) begin
            chk("lit_valid_timeout", 0, 1);
        end else begin
            chk("lit_mant0", (sel == 0) ? int'(mo_a[0]) : int'(mo_b[0]), m0);
            chk("lit_exp", (sel == 0) ? int'(eo_a) : int'(eo_b), e);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((qe_a.size() != 0 || qe_b.size() != 0) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (qe_a.size() != 0 || qe_b.size() != 0) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        int m[BS];
        int snap_m, snap_e, h0;
        for (int i = 0; i < BS; i++) begin
            mdi[i] = '0;
            mbi[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Lane 0 sums 1..4 at a common exponent.
        cfg = CW'(4);
        model_start();
        for (int k = 1; k <= 4; k++) begin
            rand_lanes(m);
            m[0] = k;
            data_beat(0, m, 7, k);
        end
        chk("model_pin_sum", m_acc[0], 10);
        push_expect(0);
        expect_lit(0, 10, 7);

        // Rising exponent shifts the accumulator; falling exponent shifts the operand.
        cfg = CW'(2);
        model_start();
        rand_lanes(m); m[0] = 8; data_beat(0, m, 5, 1);
        rand_lanes(m); m[0] = 1; data_beat(0, m, 7, 2);
        chk("model_pin_rise", m_acc[0], 3);
        push_expect(0);
        expect_lit(0, 3, 7);

        model_start();
        rand_lanes(m); m[0] = 4;  data_beat(0, m, 7, 1);
        rand_lanes(m); m[0] = -8; data_beat(0, m, 5, 2);
        chk("model_pin_fall", m_acc[0], 2);
        push_expect(0);
        expect_lit(0, 2, 7);

        // Bias at a higher exponent than the data.
        model_start();
        rand_lanes(m); m[0] = 3; data_beat(1, m, 4, 1);
        rand_lanes(m); m[0] = 3; data_beat(1, m, 4, 2);
        chk("bias_pending_din_rdy", int'(dir_b), 0);
        chk("bias_pending_bias_rdy", int'(br_b), 1);
        rand_lanes(m); m[0] = -2; bias_beat(m, 5);
        chk("model_pin_bias", m_acc[0], 1);
        push_expect(1);
        expect_lit(1, 1, 5);

        // Output backpressure.
        wait_drain();
        rdy_mode = 1;
        rdy = 1'b0;
        run_txn(0, 3, 1'b0);
        snap_m = int'(mo_a[0]);
        snap_e = int'(eo_a);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", int'(vo_a), 1);
            chk("bp_din_rdy", int'(dir_a), 0);
            chk("bp_stable_mant", int'(mo_a[0]), snap_m);
            chk("bp_stable_exp", int'(eo_a), snap_e);
        end
        @(posedge clk); #1;
        h0 = hs_a;
        rdy = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("bp_one_transfer", hs_a - h0, 1);
        chk("bp_valid_low", int'(vo_a), 0);
        chk("bp_din_rdy_back", int'(dir_a), 1);
        chk("bp_count_cleared", int'(bc_a), 0);
        rdy_mode = 0;
        run_txn(0, 2, 1'b0);

        // Depth clamping and mid-accumulation cfg changes.
        run_txn(0, 0, 1'b0);
        chk("depth0_valid", int'(vo_a), 1);
        run_txn(1, MD + 3, 1'b0);
        chk("depth_clamp_count", int'(bc_b), MD);
        run_txn(0, 5, 1'b1);
        run_txn(1, 3, 1'b1);

        // Reset mid-accumulation discards the partial sum.
        wait_drain();
        cfg = CW'(4);
        model_start();
        rand_lanes(m); data_beat(0, m, 9, 1);
        rand_lanes(m); data_beat(0, m, 3, 2);
        rst = 1'b1;
        #1;
        chk("async_rst_count", int'(bc_a), 0);
        chk("async_rst_mant", int'(mo_a[0]), 0);
        chk("async_rst_exp", int'(eo_a), 0);
        chk("async_rst_din_rdy", int'(dir_a), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_start();
        for (int k = 1; k <= 4; k++) begin
            rand_lanes(m);
            data_beat(0, m, $urandom_range(0, 15), k);
        end
        push_expect(0);

        for (int t = 0; t < 40; t++)
            run_txn(t % 2, $urandom_range(0, 20), 1'($urandom_range(0, 1)));

        wait_drain();
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
